systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
- Edge feeder for one side (rows or columns) of the integer MAC PE systolic array. Two instances are used per array: one drives the row edge, one drives the column edge.
- Accepts one NUM_LANES-wide vector per beat over a valid/ready handshake. Delays lane i by i extra cycles to form the diagonal wavefront.
- Injects zeros whenever no data is available. PEs accumulate every cycle, and a zero operand adds nothing.
- Sequences per-tile accumulator clear, streaming, zero-flush until the array has drained, and a done pulse.

Parameters:
- DATA_WIDTH, 16, width of each signed lane element (matches PE DATA_WIDTH).
- NUM_LANES, 4, number of array edges driven (rows or columns of the array).
- NUM_COLS, 4, PE hops along the orthogonal array dimension; sets flush length.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a tile; honoured only in IDLE.
- s_valid  in  1  source beat valid.
- s_ready  out  1  feeder accepts a beat this cycle.
- s_data  in  NUM_LANES*DATA_WIDTH  beat vector; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH], signed.
- s_last  in  1  marks the final beat of the tile; qualified by s_valid&s_ready.
- lane_data  out  NUM_LANES*DATA_WIDTH  skewed outputs to the array edge; same lane packing as s_data.
- acc_clr_n  out  1  active-low accumulator clear, wired to the PE array's rstn.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the tile has fully drained.

Behaviour:
- Async reset (rstn=0) values:
  - FSM returns to IDLE.
  - All skew registers and lane_data = 0.
  - s_ready=0, busy=0, done=0, acc_clr_n=1.
  - Flush counter = 0.
  - Reset asserted mid-tile abandons the tile; no done pulse is issued.
- FSM states IDLE, CLEAR, STREAM, FLUSH, DONE:
  - IDLE: s_ready=0. start=1 moves to CLEAR.
  - CLEAR: exactly one cycle. acc_clr_n=0 (registered output, low for exactly the CLEAR cycle). s_ready=0. Moves to STREAM.
  - STREAM: s_ready=1.
    - A beat accepted with s_last=1 loads flush counter = NUM_LANES+NUM_COLS-1 and moves to FLUSH.
    - s_valid=0 cycles are legal and inject a zero vector.
  - FLUSH: s_ready=0. Injects zero vectors. Counter decrements each cycle. When the counter reaches 1, the FSM moves to DONE.
  - DONE: one cycle. done=1 (registered output). Moves to IDLE.
- start outside IDLE is ignored. s_valid while s_ready=0 is ignored and no data is consumed.
- Skew timing:
  - Let the injected vector at cycle t be s_data if s_valid&s_ready, otherwise 0.
  - Lane i of lane_data at cycle t+1+i equals lane i of the vector injected at cycle t.
  - Lane 0 latency is 1 cycle; lane NUM_LANES-1 latency is NUM_LANES cycles.
  - Implementation: one registered stage on lane 0, plus i further stages on lane i (triangular shift array, NUM_LANES*(NUM_LANES+1)/2 registers).
- Skew registers shift every cycle in all states, including IDLE/CLEAR, shifting in zeros. lane_data is therefore all-zero while idle once the pipeline has emptied.
- Data is passed through unchanged: signed, no width change, no arithmetic.
- Single-beat tile: the first accepted beat carries s_last=1. The FSM goes straight to FLUSH.
- Total cycles from the s_last acceptance edge to the done pulse: NUM_LANES+NUM_COLS.

Test Plan:
- Reset then idle: rstn=0 for 3 cycles, release, no start. Required: s_ready=0, busy=0, done=0, acc_clr_n=1, lane_data=0 for 20 cycles.
- Skew check (NUM_LANES=4, NUM_COLS=4):
  - Stimulus: start, then in STREAM one beat with lanes {4,3,2,1} (lane0=1), s_last=1, accepted at edge T.
  - Required: lane0=1 at T+1, lane1=2 at T+2, lane2=3 at T+3, lane3=4 at T+4, all other cycles zero.
  - Required: done pulses for exactly one cycle at T+8; busy drops with it.
- Bubbles: 3-beat tile with s_valid pattern 1,0,1,1 and lane0 values 5,-,−7,9 (last on third beat). Required: lane0 sequence 5,0,−7,9 on consecutive cycles; no beat lost or duplicated.
- Handshake gating:
  - s_valid held high through CLEAR and FLUSH: required s_ready=0 there, and the values present on s_data never appear on lane_data.
  - start pulsed during STREAM: required to have no effect.
- Clear pulse: start at edge S. Required: acc_clr_n=0 for exactly one cycle, and s_ready first high in the cycle after CLEAR.
- Reset mid-tile: assert rstn=0 during FLUSH (counter=3). Required: immediate return to the reset values, no done pulse; a subsequent start runs a clean tile with correct skew.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Edge feeder for one side of the MAC systolic array: accepts one vector
// per beat, skews lane i by i extra cycles into a diagonal wavefront, and
// sequences accumulator clear, streaming, zero-flush and a done pulse.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = 4,
    parameter int NUM_COLS   = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] s_data,
    input  logic                            s_last,
    output logic [NUM_LANES*DATA_WIDTH-1:0] lane_data,
    output logic                            acc_clr_n,
    output logic                            busy,
    output logic                            done
);

    // Zero-flush length: the last operand must travel through every lane
    // skew stage and every PE hop before the array holds a final result.
    localparam int FLUSH_LEN = NUM_LANES + NUM_COLS - 1;
    localparam int CW        = $clog2(FLUSH_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic [CW-1:0]                   cnt;
    logic [CW-1:0]                   cnt_next;
    logic                            done_q;
    logic                            clr_n_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] inject;

    assign s_ready   = (state == STREAM);
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign acc_clr_n = clr_n_q;

    // Anything not accepted through the handshake enters the array as zero.
    assign inject = (s_valid && s_ready) ? s_data : '0;

    // State, flush counter and the registered clear/done strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            done_q  <= 1'b0;
            clr_n_q <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            done_q  <= (state_next == DONE);
            clr_n_q <= (state_next != CLEAR);
        end
    end

    // Next-state and flush-counter decode.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = STREAM;
            end
            STREAM: begin
                if (s_valid && s_last) begin
                    cnt_next   = CW'(FLUSH_LEN);
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CW'(1);
                end
                if (cnt <= CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Triangular skew array: lane i owns i+1 stages, so its latency is i+1.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] stage [0:i];

        // Shift every cycle regardless of FSM state; idle cycles shift in zeros.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int j = 0; j <= i; j++) begin
                    stage[j] <= '0;
                end
            end else begin
                stage[0] <= inject[i*DATA_WIDTH +: DATA_WIDTH];
                for (int j = 1; j <= i; j++) begin
                    stage[j] <= stage[j-1];
                end
            end
        end

        assign lane_data[i*DATA_WIDTH +: DATA_WIDTH] = stage[i];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with NUM_LANES=4, NUM_COLS=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_systolic_skew_feeder;

    localparam int DW = 16;
    localparam int NL = 4;
    localparam int NC = 4;

    logic           clk = 1'b0;
    logic           rstn;
    logic           start;
    logic           s_valid;
    logic           s_ready;
    logic [NL*DW-1:0] s_data;
    logic           s_last;
    logic [NL*DW-1:0] lane_data;
    logic           acc_clr_n;
    logic           busy;
    logic           done;

    int total = 0;
    int bad   = 0;

    systolic_skew_feeder #(
        .DATA_WIDTH(DW),
        .NUM_LANES (NL),
        .NUM_COLS  (NC)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .lane_data(lane_data),
        .acc_clr_n(acc_clr_n),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic v,
                                 input logic [NL*DW-1:0] d, input logic last);
        start   = st;
        s_valid = v;
        s_data  = d;
        s_last  = last;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Control bundle as {s_ready, busy, done, acc_clr_n}.
    function automatic logic [63:0] ctl();
        return {60'd0, s_ready, busy, done, acc_clr_n};
    endfunction

    function automatic logic [NL*DW-1:0] vec(input logic [DW-1:0] l3, input logic [DW-1:0] l2,
                                             input logic [DW-1:0] l1, input logic [DW-1:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    // Expected skew output for a single beat {4,3,2,1} accepted at edge T.
    logic [NL*DW-1:0] skew_exp [0:8];
    logic [NL*DW-1:0] skew2_exp [0:8];

    initial begin
        logic [NL*DW-1:0] junk;
        junk = 64'hDEAD_BEEF_CAFE_F00D;

        for (int k = 0; k < 9; k++) begin
            skew_exp[k]  = '0;
            skew2_exp[k] = '0;
        end
        skew_exp[0]  = vec(16'd0, 16'd0, 16'd0, 16'd1);
        skew_exp[1]  = vec(16'd0, 16'd0, 16'd2, 16'd0);
        skew_exp[2]  = vec(16'd0, 16'd3, 16'd0, 16'd0);
        skew_exp[3]  = vec(16'd4, 16'd0, 16'd0, 16'd0);
        skew2_exp[0] = vec(16'h0, 16'h0, 16'h0, 16'h10);
        skew2_exp[1] = vec(16'h0, 16'h0, 16'h20, 16'h0);
        skew2_exp[2] = vec(16'h0, 16'h30, 16'h0, 16'h0);
        skew2_exp[3] = vec(16'h40, 16'h0, 16'h0, 16'h0);

        // Reset for three cycles, then idle with no start.
        rstn = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 3; k++) tick();
        checkOutput("rst_ctl", ctl(), 64'b0001);
        checkOutput("rst_lanes", lane_data, '0);
        rstn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checkOutput("idle_ctl", ctl(), 64'b0001);
            checkOutput("idle_lanes", lane_data, '0);
        end

        // Clear pulse and skew check; junk held valid through CLEAR.
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick();
        checkOutput("clear_ctl", ctl(), 64'b0100);
        applyStimulus(1'b0, 1'b1, junk, 1'b1);
        tick();
        checkOutput("stream_ctl", ctl(), 64'b1101);
        checkOutput("stream_lanes", lane_data, '0);
        applyStimulus(1'b0, 1'b1, vec(16'd4, 16'd3, 16'd2, 16'd1), 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, junk, 1'b1);
        for (int k = 0; k < 9; k++) begin
            checkOutput($sformatf("skew_lanes_%0d", k), lane_data, skew_exp[k]);
            checkOutput($sformatf("skew_done_%0d", k), {63'd0, done}, {63'd0, k == 7});
            checkOutput($sformatf("skew_busy_%0d", k), {63'd0, busy}, {63'd0, k < 8});
            checkOutput($sformatf("skew_rdy_%0d", k), {63'd0, s_ready}, 64'd0);
            if (k < 8) tick();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // Bubbles: valid 1,0,1,1 with lane0 5,-,-7,9; start pulsed in STREAM.
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        tick();
        checkOutput("bub_ready", {63'd0, s_ready}, 64'd1);
        applyStimulus(1'b1, 1'b1, vec(16'h33, 16'd0, 16'd0, 16'd5), 1'b0);
        tick();
        checkOutput("bub_l0_a", {48'd0, lane_data[15:0]}, 64'd5);
        checkOutput("bub_start_ign", ctl(), 64'b1101);
        applyStimulus(1'b0, 1'b0, vec(16'd0, 16'd0, 16'd0, 16'd77), 1'b0);
        tick();
        checkOutput("bub_l0_b", {48'd0, lane_data[15:0]}, 64'd0);
        applyStimulus(1'b0, 1'b1, vec(16'd0, 16'd0, 16'd0, 16'hFFF9), 1'b0);
        tick();
        checkOutput("bub_l0_c", {48'd0, lane_data[15:0]}, 64'h0000_0000_0000_FFF9);
        applyStimulus(1'b0, 1'b1, vec(16'd0, 16'd0, 16'd0, 16'd9), 1'b1);
        tick();
        checkOutput("bub_l0_d", {48'd0, lane_data[15:0]}, 64'd9);
        checkOutput("bub_l3_skew", {48'd0, lane_data[63:48]}, 64'h33);
        checkOutput("bub_flush_ctl", ctl(), 64'b0101);
        applyStimulus(1'b1, 1'b1, junk, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) applyStimulus(1'b0, 1'b1, junk, 1'b0);
            checkOutput($sformatf("bub_done_%0d", k), {63'd0, done}, {63'd0, k == 7});
            checkOutput($sformatf("bub_l0_flush_%0d", k), {48'd0, lane_data[15:0]}, 64'd0);
        end
        checkOutput("bub_idle_ctl", ctl(), 64'b0001);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // Reset during FLUSH with counter at 3, then a clean tile.
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, vec(16'd8, 16'd7, 16'd6, 16'd5), 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        checkOutput("mid_busy_pre", {63'd0, busy}, 64'd1);
        rstn = 1'b0;
        #1;
        checkOutput("mid_rst_ctl", ctl(), 64'b0001);
        checkOutput("mid_rst_lanes", lane_data, '0);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("mid_rst_done", {63'd0, done}, 64'd0);
        end
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput("post_rst_done", {63'd0, done}, 64'd0);
            checkOutput("post_rst_ctl", ctl(), 64'b0001);
        end

        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick();
        checkOutput("re_clear", {63'd0, acc_clr_n}, 64'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, vec(16'h40, 16'h30, 16'h20, 16'h10), 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            checkOutput($sformatf("re_lanes_%0d", k), lane_data, skew2_exp[k]);
            checkOutput($sformatf("re_done_%0d", k), {63'd0, done}, {63'd0, k == 7});
            if (k < 8) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
